// File: rtl/satd_pkg.sv
// Shared types and width helpers for the SATD best-match search.
package satd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int RES_W_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A sum of n results of res_w bits never needs more than res_w + clog2(n) bits.
    function automatic int cost_width(input int res_w, input int subblocks);
        return res_w + clog2(subblocks);
    endfunction

    function automatic int idx_width(input int num_cand);
        return (clog2(num_cand) > 0) ? clog2(num_cand) : 1;
    endfunction

endpackage

// File: rtl/satd_cost_acc.sv
// Sums SUBBLOCKS consecutive SATD results into one candidate cost.
module satd_cost_acc
    import satd_pkg::*;
#(
    parameter int SUBBLOCKS = 4,
    parameter int RES_W     = RES_W_DEF,
    parameter int COST_W    = cost_width(RES_W, SUBBLOCKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              consume,
    input  logic [RES_W-1:0]  result,
    output logic [COST_W-1:0] total,
    output logic              last_sub
);

    localparam int SUB_W = (clog2(SUBBLOCKS) > 0) ? clog2(SUBBLOCKS) : 1;

    logic [COST_W-1:0] acc_reg;
    logic [SUB_W-1:0]  sub_cnt_reg;

    // total includes the result being consumed this cycle, so the last one lands in the compare directly.
    assign total    = acc_reg + COST_W'(result);
    assign last_sub = (sub_cnt_reg == SUB_W'(SUBBLOCKS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_reg     <= '0;
            sub_cnt_reg <= '0;
        end else if (consume) begin
            if (last_sub) begin
                acc_reg     <= '0;
                sub_cnt_reg <= '0;
            end else begin
                acc_reg     <= total;
                sub_cnt_reg <= sub_cnt_reg + SUB_W'(1);
            end
        end
    end

endmodule

// File: rtl/satd_best_match.sv
// Accumulates per-candidate SATD costs and reports the lowest-cost candidate.
module satd_best_match
    import satd_pkg::*;
#(
    parameter int SUBBLOCKS = 4,
    parameter int NUM_CAND  = 16,
    parameter int RES_W     = RES_W_DEF,
    parameter int COST_W    = cost_width(RES_W, SUBBLOCKS),
    parameter int IDX_W     = idx_width(NUM_CAND)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RES_W-1:0]  satd_result,
    input  logic              satd_done,
    output logic              satd_ack,
    output logic [COST_W-1:0] best_cost,
    output logic [IDX_W-1:0]  best_idx,
    output logic              best_valid,
    input  logic              best_ack,
    output logic              busy
);

    state_t            state_reg;
    logic [IDX_W-1:0]  cand_cnt_reg;
    logic [COST_W-1:0] min_cost_reg;
    logic [IDX_W-1:0]  min_idx_reg;
    logic [COST_W-1:0] best_cost_reg;
    logic [IDX_W-1:0]  best_idx_reg;
    logic              best_valid_reg;
    logic              satd_ack_reg;
    logic              busy_reg;

    logic              consume;
    logic              clear;
    logic [COST_W-1:0] total;
    logic              last_sub;
    logic              take_new;
    logic [COST_W-1:0] min_cost_next;
    logic [IDX_W-1:0]  min_idx_next;

    assign consume = satd_done && satd_ack_reg;
    assign clear   = (state_reg == IDLE) && start;

    satd_cost_acc #(
        .SUBBLOCKS (SUBBLOCKS),
        .RES_W     (RES_W),
        .COST_W    (COST_W)
    ) u_cost_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .consume  (consume),
        .result   (satd_result),
        .total    (total),
        .last_sub (last_sub)
    );

    // Strict less-than keeps the earliest candidate on ties.
    always_comb begin
        take_new      = 1'b0;
        min_cost_next = min_cost_reg;
        min_idx_next  = min_idx_reg;
        if (total < min_cost_reg) begin
            take_new      = 1'b1;
            min_cost_next = total;
            min_idx_next  = cand_cnt_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cand_cnt_reg   <= '0;
            min_cost_reg   <= '0;
            min_idx_reg    <= '0;
            best_cost_reg  <= '0;
            best_idx_reg   <= '0;
            best_valid_reg <= 1'b0;
            satd_ack_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cand_cnt_reg <= '0;
                        min_cost_reg <= '1;
                        min_idx_reg  <= '0;
                        satd_ack_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (consume && last_sub) begin
                        if (take_new) begin
                            min_cost_reg <= min_cost_next;
                            min_idx_reg  <= min_idx_next;
                        end
                        if (cand_cnt_reg == IDX_W'(NUM_CAND - 1)) begin
                            best_cost_reg  <= min_cost_next;
                            best_idx_reg   <= min_idx_next;
                            best_valid_reg <= 1'b1;
                            satd_ack_reg   <= 1'b0;
                            state_reg      <= REPORT;
                        end else begin
                            cand_cnt_reg <= cand_cnt_reg + IDX_W'(1);
                        end
                    end
                end
                REPORT: begin
                    if (best_ack) begin
                        best_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    satd_ack_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign satd_ack   = satd_ack_reg;
    assign best_cost  = best_cost_reg;
    assign best_idx   = best_idx_reg;
    assign best_valid = best_valid_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_satd_best_match.sv
// Directed bench for satd_best_match with SUBBLOCKS=4, NUM_CAND=4.
module tb_satd_best_match;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] satd_result;
    logic        satd_done;
    logic        satd_ack;
    logic [17:0] best_cost;
    logic [1:0]  best_idx;
    logic        best_valid;
    logic        best_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    satd_best_match #(
        .SUBBLOCKS (4),
        .NUM_CAND  (4),
        .RES_W     (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .satd_result (satd_result),
        .satd_done   (satd_done),
        .satd_ack    (satd_ack),
        .best_cost   (best_cost),
        .best_idx    (best_idx),
        .best_valid  (best_valid),
        .best_ack    (best_ack),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Presents one result at a negedge and returns on the negedge after it is consumed.
    task automatic send(input logic [15:0] r);
        int n;
        n = 0;
        satd_done   = 1'b1;
        satd_result = r;
        while (satd_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL send_timeout observed=ack_low expected=ack_high");
        end
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_ack();
        best_ack = 1'b1;
        @(negedge clk);
        best_ack = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        satd_done   = 1'b1;
        satd_result = 16'h0050;
        best_ack    = 1'b0;

        // Reset with a pending result that must never be taken.
        repeat (3) @(negedge clk);
        check("rst_cost", 32'(best_cost), 32'h0);
        check("rst_idx", 32'(best_idx), 32'h0);
        check("rst_valid", 32'(best_valid), 32'h0);
        check("rst_ack", 32'(satd_ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ack", 32'(satd_ack), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        satd_done = 1'b0;

        // Basic search: costs 40, 20, 120, 10.
        do_start();
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_ack", 32'(satd_ack), 32'h1);
        repeat (4) send(16'd10);
        repeat (4) send(16'd5);
        repeat (4) send(16'd30);
        send(16'd1);
        send(16'd2);
        send(16'd3);
        check("basic_valid_before", 32'(best_valid), 32'h0);
        send(16'd4);
        check("basic_valid_after", 32'(best_valid), 32'h1);
        satd_done = 1'b0;
        check("basic_cost", 32'(best_cost), 32'd10);
        check("basic_idx", 32'(best_idx), 32'd3);
        check("basic_report_ack", 32'(satd_ack), 32'h0);
        do_ack();
        check("basic_done_valid", 32'(best_valid), 32'h0);
        check("basic_done_busy", 32'(busy), 32'h0);
        check("basic_hold_cost", 32'(best_cost), 32'd10);

        // Tie and stall: costs 20, 20, 50, 20 with 3 idle cycles between results.
        do_start();
        check("tie_hold_cost_accum", 32'(best_cost), 32'd10);
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 4; s++) begin
                if (c == 2) send((s < 2) ? 16'd12 : 16'd13);
                else send(16'd5);
                satd_done = 1'b0;
                if (!(c == 3 && s == 3)) repeat (3) @(negedge clk);
            end
        end
        check("tie_valid", 32'(best_valid), 32'h1);
        check("tie_cost", 32'(best_cost), 32'd20);
        check("tie_idx", 32'(best_idx), 32'd0);
        do_ack();

        // Width: sixteen 0xFFFF results, each candidate sums to 0x3FFFC.
        do_start();
        repeat (16) send(16'hFFFF);
        satd_done = 1'b0;
        check("width_valid", 32'(best_valid), 32'h1);
        check("width_cost", 32'(best_cost), 32'h3FFFC);
        check("width_idx", 32'(best_idx), 32'd0);

        // Handshake: winner holds while unacknowledged.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(best_valid), 32'h1);
            check("hold_cost", 32'(best_cost), 32'h3FFFC);
        end
        best_ack = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        best_ack = 1'b0;
        start    = 1'b0;
        check("ackstart_valid", 32'(best_valid), 32'h0);
        check("ackstart_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        check("ackstart_still_idle", 32'(busy), 32'h0);
        check("ackstart_no_ack", 32'(satd_ack), 32'h0);

        // Reset after 7 zero results that would otherwise win with cost 0.
        do_start();
        repeat (7) send(16'd0);
        satd_done = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ack", 32'(satd_ack), 32'h0);
        check("midrst_cost", 32'(best_cost), 32'h0);
        check("midrst_valid", 32'(best_valid), 32'h0);
        do_start();
        send(16'd3); send(16'd2); send(16'd2); send(16'd2);
        send(16'd2); send(16'd2); send(16'd2); send(16'd2);
        send(16'd1); send(16'd2); send(16'd2); send(16'd2);
        send(16'd0); send(16'd0); send(16'd0); send(16'd6);
        satd_done = 1'b0;
        check("fresh_valid", 32'(best_valid), 32'h1);
        check("fresh_cost", 32'(best_cost), 32'd6);
        check("fresh_idx", 32'(best_idx), 32'd3);
        do_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
